// File: rtl/menu_pkg.sv
// Shared types and constants for the front-panel menu controller.
// Holds state encodings, button indices and small decode helpers.
package menu_pkg;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t MENU_P1 = 3'd0;
  localparam state_t MENU_P2 = 3'd1;
  localparam state_t GAME_1P = 3'd2;
  localparam state_t GAME_2P = 3'd3;

  // Lower index wins when presses collide.
  localparam int BTN_N    = 4;
  localparam int BTN_BACK = 0;
  localparam int BTN_SEL  = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;

  // Keep only the lowest set bit, i.e. the highest-priority press.
  function automatic logic [BTN_N-1:0] pick_press(
    input logic [BTN_N-1:0] p
  );
    return p & (~p + 1'b1);
  endfunction

  function automatic logic is_menu(input state_t s);
    return (s == MENU_P1) || (s == MENU_P2);
  endfunction

  function automatic logic is_game(input state_t s);
    return (s == GAME_1P) || (s == GAME_2P);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button path: 2-FF synchroniser, debounce counter, rising-edge pulse.
// Ports: clk, rst (async active-low), btn (raw async), press (1-cycle pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic [1:0]       sync_q;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive samples that differ from the accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_q <= level;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/menu_state_ctrl.sv
// Menu/game FSM driving the VGA display state from four debounced buttons.
// Ports: clk, rst (async active-low), btn_up/down/sel/back (raw), vsync,
//   state[2:0], game_start (pulse), pending. Option: MENU_FRAME_SYNC_EN.
module menu_state_ctrl
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_back,
  input  logic       vsync,
  output logic [2:0] state,
  output logic       game_start,
  output logic       pending
);

  logic [BTN_N-1:0] raw;
  logic [BTN_N-1:0] press;
  logic [BTN_N-1:0] hot;
  state_t           next_state;
  state_t           ns_d;
  logic             load;

  assign raw[BTN_BACK] = btn_back;
  assign raw[BTN_SEL]  = btn_sel;
  assign raw[BTN_UP]   = btn_up;
  assign raw[BTN_DOWN] = btn_down;

  for (genvar i = 0; i < BTN_N; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (raw[i]),
      .press(press[i])
    );
  end

  assign hot = pick_press(press);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_state <= MENU_P1;
    end else begin
      next_state <= ns_d;
    end
  end

  always_comb begin
    ns_d = next_state;
    case (next_state)
      MENU_P1: begin
        unique case (1'b1)
          hot[BTN_SEL]:  ns_d = GAME_1P;
          hot[BTN_UP],
          hot[BTN_DOWN]: ns_d = MENU_P2;
          default:       ns_d = next_state;
        endcase
      end
      MENU_P2: begin
        unique case (1'b1)
          hot[BTN_SEL]:  ns_d = GAME_2P;
          hot[BTN_UP],
          hot[BTN_DOWN]: ns_d = MENU_P1;
          default:       ns_d = next_state;
        endcase
      end
      GAME_1P,
      GAME_2P: begin
        if (hot[BTN_BACK]) ns_d = MENU_P1;
      end
      default: ns_d = MENU_P1;
    endcase
  end

`ifdef MENU_FRAME_SYNC_EN
  logic vsync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  // Falling vsync edge: safe point to swap the displayed state.
  assign load = ~vsync & vsync_q;
`else
  logic vsync_unused;
  assign vsync_unused = vsync;
  assign load         = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MENU_P1;
      game_start <= 1'b0;
    end else begin
      game_start <= load & is_menu(state) & is_game(next_state);
      if (load) state <= next_state;
    end
  end

  always_comb begin
    pending = (next_state != state);
  end

endmodule

// File: doc/menu_state_ctrl.md
# menu_state_ctrl

Front-panel menu controller that turns raw push-button inputs into the 3-bit `state` consumed by the VGA image display stage. It sits directly upstream of the display:
- synchronises and debounces four buttons;
- runs the menu/game state machine;
- optionally defers visible `state` changes to the VGA frame boundary so the player-select overlay never tears mid-frame.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000 — consecutive stable samples required to accept a button level (10 ms at 25 MHz)
- CNT_W, 18 — debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
- clk  in  1  25 MHz pixel clock, same clock as the VGA display stage
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- btn_up  in  1  raw button, active-high, asynchronous to clk
- btn_down  in  1  raw button, active-high, asynchronous
- btn_sel  in  1  raw button, active-high, asynchronous
- btn_back  in  1  raw button, active-high, asynchronous
- vsync  in  1  vsync from the VGA driver, active-low pulse, clk domain
- state  out  3  displayed state: 0 MENU_P1, 1 MENU_P2, 2 GAME_1P, 3 GAME_2P
- game_start  out  1  one-cycle pulse when `state` becomes GAME_1P or GAME_2P
- pending  out  1  high while a state change is waiting for the frame boundary

## Operation
- Each button path:
  - 2-FF synchroniser;
  - debounce counter that resets on any mismatch between the synchronised sample and the accepted level; the accepted level flips when the counter reaches DEBOUNCE_CYCLES-1;
  - rising-edge detector on the accepted level gives a 1-cycle press pulse.
- Release is debounced identically and produces no pulse.
- FSM (`next_state` register) transitions on press pulses:
  - MENU_P1: up or down → MENU_P2; sel → GAME_1P
  - MENU_P2: up or down → MENU_P1; sel → GAME_2P
  - GAME_1P / GAME_2P: back → MENU_P1; all other presses ignored
  - back in a MENU state is ignored.
- Simultaneous pulses in one cycle use priority back > sel > up > down. Only the highest-priority pulse is acted on; the others are dropped.
- Encodings 4–7 are illegal; if reached, the FSM returns to MENU_P1 on the next cycle.
- `state` is a separate output register loaded from `next_state` (see Configuration).
- `game_start` is asserted in the cycle `state` is loaded with GAME_1P or GAME_2P from a MENU value.
- Reset values:
  - state = 0, next_state = 0, game_start = 0, pending = 0;
  - all debounce counters 0, accepted levels 0;
  - synchronisers 0; previous-vsync register 1.
- Reset mid-debounce or mid-pending discards all progress. A button held through reset release must be stable for DEBOUNCE_CYCLES and then produces one press pulse.

## Timing
- Latency from a clean raw edge to the press pulse: 2 (sync) + DEBOUNCE_CYCLES cycles, ±1.
- `next_state` updates 1 cycle after the press pulse.
- Frame boundary = cycle in which vsync is 0 and the registered previous vsync is 1 (falling edge).
- `pending` = (next_state != state). It is combinational from registers and has no extra latency.
- If a second press changes `next_state` back to `state` before the boundary, `pending` drops and no load and no `game_start` occur.

## Configuration
- MENU_FRAME_SYNC_EN defined:
  - `state` loads from `next_state` only in the frame-boundary cycle;
  - a boundary that coincides with a `next_state` update loads the old `next_state`, and the new value waits for the next frame.
- MENU_FRAME_SYNC_EN undefined:
  - `state` loads `next_state` every cycle, so it is 1 cycle behind `next_state`;
  - vsync is unused;
  - `pending` is high for at most 1 cycle per change.

## Structure
- Package menu_pkg holds:
  - the state typedef/localparams (MENU_P1, MENU_P2, GAME_1P, GAME_2P, width 3);
  - the button priority index constants.
- One sub-module, btn_debounce (synchroniser + counter + edge detect, parameterised by DEBOUNCE_CYCLES and CNT_W), instantiated four times.
- The FSM and the frame-sync register stay in menu_state_ctrl.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, vsync period 100 cycles, low for 2.
- Reset (rst=0 for 3 cycles, then 1) → state=0, game_start=0, pending=0; with no buttons pressed, no change over 500 cycles.
- btn_down high for 10 cycles with a 1-cycle glitch at cycle 2 → exactly one press.
  - Without the macro: state=1 within 2+4+2+2 cycles.
  - With the macro: pending=1 until the next vsync falling edge, then state=1.
- MENU_P1, btn_sel held 20 cycles → state=2 and game_start high exactly 1 cycle. A subsequent btn_up press leaves state=2.
- In GAME_2P, btn_back and btn_sel debounced in the same cycle → back wins, state=0, no game_start.
- Macro on: down, then up before the vsync edge → pending returns to 0; state stays 0 across the boundary; no game_start.
- Reset asserted while btn_up is half-debounced and a change is pending → all outputs 0 immediately (asynchronous). After release, holding btn_up for 6 cycles yields one press → state=1.
